// File: rtl/hazard_controller.sv
// Pipeline sequencing controller for the 5-stage core: stall/flush enables from
// memory waits, taken branches and load-use hazards, plus a memory-wait watchdog.
module hazard_controller #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1_D,
  input  logic [4:0]       Rs2_D,
  input  logic             Uses_Rs2_D,
  input  logic             MemRead_E,
  input  logic [4:0]       Rd_E,
  input  logic             PCSrc_E,
  input  logic             MemAccess_M,
  input  logic             dmem_ready,
  output logic             PC_Stall,
  output logic             IF_ID_Stall,
  output logic             ID_EX_Stall,
  output logic             EX_MEM_Stall,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             MEM_WB_Flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [15:0]      TIMEOUT_L = 16'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           r_state;
  state_t           w_nextState;
  logic [15:0]      r_waitCnt;
  logic [15:0]      w_nextWait;
  logic             r_memTimeout;
  logic [CNT_W-1:0] r_stallCount;
  logic [CNT_W-1:0] r_flushCount;

  logic w_memStall;
  logic w_loadUse;
  logic w_memOut;
  logic w_branchOut;
  logic w_loadUseOut;

  assign w_memStall = MemAccess_M & ~dmem_ready;
  assign w_loadUse  = MemRead_E & (Rd_E != 5'd0) &
                      ((Rd_E == Rs1_D) | (Uses_Rs2_D & (Rd_E == Rs2_D)));

  // Memory stall outranks branch, which outranks load-use; ERROR freezes everything.
  always_comb begin
    w_nextState  = r_state;
    w_nextWait   = r_waitCnt;
    w_memOut     = 1'b0;
    w_branchOut  = 1'b0;
    w_loadUseOut = 1'b0;
    case (r_state)
      RUN: begin
        if (w_memStall) begin
          w_memOut    = 1'b1;
          w_nextState = MEM_WAIT;
          w_nextWait  = 16'd1;
        end else if (PCSrc_E) begin
          w_branchOut = 1'b1;
        end else if (w_loadUse) begin
          w_loadUseOut = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (w_memStall) begin
          w_memOut = 1'b1;
          if (r_waitCnt >= TIMEOUT_L) begin
            w_nextState = ERROR;
          end else begin
            w_nextWait = r_waitCnt + 16'd1;
          end
        end else begin
          w_nextState = RUN;
          w_nextWait  = 16'd0;
          if (PCSrc_E) begin
            w_branchOut = 1'b1;
          end else if (w_loadUse) begin
            w_loadUseOut = 1'b1;
          end
        end
      end
      ERROR: begin
        w_memOut = 1'b1;
      end
      default: begin
        w_nextState = RUN;
        w_nextWait  = 16'd0;
      end
    endcase
  end

  always_comb begin
    PC_Stall     = 1'b0;
    IF_ID_Stall  = 1'b0;
    ID_EX_Stall  = 1'b0;
    EX_MEM_Stall = 1'b0;
    IF_ID_Flush  = 1'b0;
    ID_EX_Flush  = 1'b0;
    MEM_WB_Flush = 1'b0;
    if (!reset) begin
      PC_Stall     = w_memOut | w_loadUseOut;
      IF_ID_Stall  = w_memOut | w_loadUseOut;
      ID_EX_Stall  = w_memOut;
      EX_MEM_Stall = w_memOut;
      IF_ID_Flush  = w_branchOut;
      ID_EX_Flush  = w_branchOut | w_loadUseOut;
      MEM_WB_Flush = w_memOut;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= RUN;
      r_waitCnt    <= 16'd0;
      r_memTimeout <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_waitCnt    <= w_nextWait;
      r_memTimeout <= (w_nextState == ERROR);
    end
  end

  // Counters saturate instead of wrapping so a long run never reads as a short one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stallCount <= '0;
      r_flushCount <= '0;
    end else begin
      if (PC_Stall && (r_stallCount != CNT_MAX)) begin
        r_stallCount <= r_stallCount + 1'b1;
      end
      if (w_branchOut && (r_flushCount != CNT_MAX)) begin
        r_flushCount <= r_flushCount + 1'b1;
      end
    end
  end

  assign mem_timeout = r_memTimeout;
  assign stall_count = r_stallCount;
  assign flush_count = r_flushCount;

endmodule
